// File: rtl/apb_cmd_pkg.sv
// Shared types and storage-word layout for the APB command queue.
// A stored command is packed as {slave_id, write, wdata, addr}, with addr in the LSBs.
package apb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ADDR,
        WAIT_DATA
    } head_state_e;

    localparam int unsigned ADDR_LSB = 0;

    function automatic int unsigned wdata_lsb(input int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned write_bit(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

    function automatic int unsigned slave_id_lsb(input int unsigned aw, input int unsigned dw);
        return aw + dw + 1;
    endfunction

    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw,
                                              input int unsigned sw);
        return aw + dw + 1 + sw;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous FIFO that keeps an occupancy counter.
// Full and empty are derived from that counter, and the head entry is read combinationally.
module apb_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/apb_cmd_queue.sv
// Per-master command queue in front of an APB master.
// It buffers whole commands and splits the head command onto separate address and write-data valid/ready channels.
module apb_cmd_queue
    import apb_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SLAVE_ID_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned LEVEL_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      I_PCLK,
    input  logic                      I_PRESET,
    input  logic                      I_CMD_VALID,
    output logic                      O_CMD_READY,
    input  logic [ADDR_WIDTH-1:0]     I_CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]     I_CMD_WDATA,
    input  logic                      I_CMD_WRITE,
    input  logic [SLAVE_ID_WIDTH-1:0] I_CMD_SLAVE_ID,
    output logic [ADDR_WIDTH-1:0]     O_PADDR,
    output logic                      O_PADDR_VALID,
    input  logic                      I_PADDR_READY,
    output logic [DATA_WIDTH-1:0]     O_PWDATA,
    output logic                      O_PWDATA_VALID,
    input  logic                      I_PWDATA_READY,
    output logic                      O_PWRITE,
    output logic [SLAVE_ID_WIDTH-1:0] O_PSLAVE_ID,
    output logic [LEVEL_WIDTH-1:0]    O_LEVEL,
    output logic                      O_EMPTY,
    output logic                      O_CMD_DONE
);

    localparam int unsigned CMD_W     = cmd_width(ADDR_WIDTH, DATA_WIDTH, SLAVE_ID_WIDTH);
    localparam int unsigned WDATA_LSB = wdata_lsb(ADDR_WIDTH);
    localparam int unsigned WRITE_BIT = write_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned SID_LSB   = slave_id_lsb(ADDR_WIDTH, DATA_WIDTH);

    head_state_e state;
    head_state_e next_state;

    logic [CMD_W-1:0]          push_word;
    logic [CMD_W-1:0]          head_word;
    logic [LEVEL_WIDTH-1:0]    level;
    logic                      full;
    logic                      empty;
    logic                      push_fire;
    logic [ADDR_WIDTH-1:0]     head_addr;
    logic [DATA_WIDTH-1:0]     head_wdata;
    logic                      head_write;
    logic [SLAVE_ID_WIDTH-1:0] head_sid;
    logic                      head_live;
    logic                      paddr_valid;
    logic                      pwdata_valid;
    logic                      addr_hs;
    logic                      data_hs;
    logic                      addr_complete;
    logic                      data_complete;
    logic                      retire;
    logic                      more_left;

    assign push_word = {I_CMD_SLAVE_ID, I_CMD_WRITE, I_CMD_WDATA, I_CMD_ADDR};
    assign push_fire = I_CMD_VALID && !full;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (I_PCLK),
        .rst       (I_PRESET),
        .push      (I_CMD_VALID),
        .push_data (push_word),
        .pop       (retire),
        .head_data (head_word),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign head_addr  = head_word[ADDR_LSB +: ADDR_WIDTH];
    assign head_wdata = head_word[WDATA_LSB +: DATA_WIDTH];
    assign head_write = head_word[WRITE_BIT];
    assign head_sid   = head_word[SID_LSB +: SLAVE_ID_WIDTH];

    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Entry state carries the per-channel done flags.
    // A push into an empty queue goes straight to ISSUE, so VALID shows one cycle after the push.
    always_comb begin
        paddr_valid  = 1'b0;
        pwdata_valid = 1'b0;
        unique case (state)
            ISSUE: begin
                paddr_valid  = 1'b1;
                pwdata_valid = head_write;
            end
            WAIT_ADDR: paddr_valid  = 1'b1;
            WAIT_DATA: pwdata_valid = 1'b1;
            default: ;
        endcase

        addr_hs       = paddr_valid && I_PADDR_READY;
        data_hs       = pwdata_valid && I_PWDATA_READY;
        addr_complete = (state == WAIT_DATA) || addr_hs;
        data_complete = (state == WAIT_ADDR) || ((state == ISSUE) && !head_write) || data_hs;
        retire        = (state != IDLE) && addr_complete && data_complete;
        more_left     = (level > LEVEL_WIDTH'(1)) || push_fire;

        next_state = state;
        unique case (state)
            IDLE: begin
                if (push_fire) begin
                    next_state = ISSUE;
                end
            end
            default: begin
                if (retire) begin
                    next_state = more_left ? ISSUE : IDLE;
                end else if (state == ISSUE) begin
                    if (addr_hs) begin
                        next_state = WAIT_DATA;
                    end else if (data_hs) begin
                        next_state = WAIT_ADDR;
                    end
                end
            end
        endcase
    end

    assign head_live = (state != IDLE);

    assign O_CMD_READY    = !full;
    assign O_PADDR_VALID  = paddr_valid;
    assign O_PWDATA_VALID = pwdata_valid;
    assign O_PADDR        = head_live ? head_addr : '0;
    assign O_PWDATA       = (head_live && head_write) ? head_wdata : '0;
    assign O_PWRITE       = head_live && head_write;
    assign O_PSLAVE_ID    = head_live ? head_sid : '0;
    assign O_LEVEL        = level;
    assign O_EMPTY        = empty;
    assign O_CMD_DONE     = retire;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Bench for apb_cmd_queue.
// Each cycle's outputs are compared against a queue-based model of the command stream.
module tb_apb_cmd_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [1:0]  sid;
    } cmd_t;

    logic        clk = 1'b0;
    logic        I_PRESET = 1'b1;
    logic        I_CMD_VALID = 1'b0;
    logic        O_CMD_READY;
    logic [31:0] I_CMD_ADDR = '0;
    logic [31:0] I_CMD_WDATA = '0;
    logic        I_CMD_WRITE = 1'b0;
    logic [1:0]  I_CMD_SLAVE_ID = '0;
    logic [31:0] O_PADDR;
    logic        O_PADDR_VALID;
    logic        I_PADDR_READY = 1'b0;
    logic [31:0] O_PWDATA;
    logic        O_PWDATA_VALID;
    logic        I_PWDATA_READY = 1'b0;
    logic        O_PWRITE;
    logic [1:0]  O_PSLAVE_ID;
    logic [2:0]  O_LEVEL;
    logic        O_EMPTY;
    logic        O_CMD_DONE;

    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    cmd_t q[$];
    logic a_done = 1'b0;
    logic d_done = 1'b0;
    logic model_ok = 1'b0;

    always #5 clk = ~clk;

    apb_cmd_queue #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SLAVE_ID_WIDTH (2),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .I_PCLK         (clk),
        .I_PRESET       (I_PRESET),
        .I_CMD_VALID    (I_CMD_VALID),
        .O_CMD_READY    (O_CMD_READY),
        .I_CMD_ADDR     (I_CMD_ADDR),
        .I_CMD_WDATA    (I_CMD_WDATA),
        .I_CMD_WRITE    (I_CMD_WRITE),
        .I_CMD_SLAVE_ID (I_CMD_SLAVE_ID),
        .O_PADDR        (O_PADDR),
        .O_PADDR_VALID  (O_PADDR_VALID),
        .I_PADDR_READY  (I_PADDR_READY),
        .O_PWDATA       (O_PWDATA),
        .O_PWDATA_VALID (O_PWDATA_VALID),
        .I_PWDATA_READY (I_PWDATA_READY),
        .O_PWRITE       (O_PWRITE),
        .O_PSLAVE_ID    (O_PSLAVE_ID),
        .O_LEVEL        (O_LEVEL),
        .O_EMPTY        (O_EMPTY),
        .O_CMD_DONE     (O_CMD_DONE)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle.
    // Inputs are driven just after the falling edge and outputs are compared 1ns later.
    // The model is then advanced across the rising edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [1:0] s,
                        input logic pr, input logic dr, input logic rst);
        cmd_t        hd;
        cmd_t        c;
        int unsigned sz;
        logic        hav, hdv, ret, pushed;
        I_CMD_VALID    = v;
        I_CMD_ADDR     = a;
        I_CMD_WDATA    = d;
        I_CMD_WRITE    = w;
        I_CMD_SLAVE_ID = s;
        I_PADDR_READY  = pr;
        I_PWDATA_READY = dr;
        I_PRESET       = rst;
        #1;
        sz  = q.size();
        hd  = (sz > 0) ? q[0] : '{addr: '0, wdata: '0, write: 1'b0, sid: '0};
        hav = (sz > 0) && !a_done;
        hdv = (sz > 0) && hd.write && !d_done;
        ret = (sz > 0) && (a_done || (hav && pr)) && (!hd.write || d_done || (hdv && dr));
        if (model_ok) begin
            check("cmd_ready", O_CMD_READY, sz < DEPTH);
            check("level", O_LEVEL, sz);
            check("empty", O_EMPTY, sz == 0);
            check("paddr_valid", O_PADDR_VALID, hav);
            check("pwdata_valid", O_PWDATA_VALID, hdv);
            check("paddr", O_PADDR, (sz > 0) ? hd.addr : 32'h0);
            check("pwdata", O_PWDATA, (sz > 0 && hd.write) ? hd.wdata : 32'h0);
            check("pwrite", O_PWRITE, (sz > 0) && hd.write);
            check("pslave_id", O_PSLAVE_ID, (sz > 0) ? hd.sid : 2'd0);
            check("cmd_done", O_CMD_DONE, ret);
        end
        if (O_CMD_DONE === 1'b1) done_count++;
        pushed = v && (sz < DEPTH);
        c = '{addr: a, wdata: d, write: w, sid: s};
        @(posedge clk);
        if (rst) begin
            q.delete();
            a_done   = 1'b0;
            d_done   = 1'b0;
            model_ok = 1'b1;
        end else begin
            if (ret) begin
                void'(q.pop_front());
                a_done = 1'b0;
                d_done = 1'b0;
            end else if (sz > 0) begin
                if (hav && pr) a_done = 1'b1;
                if (hdv && dr) d_done = 1'b1;
            end
            if (pushed) q.push_back(c);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic pr, input logic dr);
        step(1'b0, '0, '0, 1'b0, 2'd0, pr, dr, 1'b0);
    endtask

    initial begin
        step(1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("rst_ready", O_CMD_READY, 1'b1);
        check("rst_empty", O_EMPTY, 1'b1);

        // Single write with both readies high.
        step(1'b1, 32'h10, 32'hA5, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check("write_drained", O_LEVEL, 3'd0);

        // A read retires on the address handshake alone.
        step(1'b1, 32'h20, 32'hDEAD, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);

        // The address is held off for three cycles while data is accepted.
        step(1'b1, 32'h10, 32'h5A, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);

        // Fill to full, attempt a push while full, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h100 + i, 32'h200 + i, i[0], i[1:0], 1'b0, 1'b0, 1'b0);
        check("full_level", O_LEVEL, 3'd4);
        check("full_ready", O_CMD_READY, 1'b0);
        done_count = 0;
        step(1'b1, 32'hBAD, 32'hBAD, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b1);
        check("drain_count", done_count, DEPTH);

        // Streaming: one push and one retire per cycle.
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'h300 + i, 32'h400 + i, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Reset while the head waits on its data channel with three entries queued.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h500 + i, 32'h600 + i, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("rst_paddr_valid", O_PADDR_VALID, 1'b0);
        check("rst_pwdata_valid", O_PWDATA_VALID, 1'b0);
        check("rst_level", O_LEVEL, 3'd0);
        check("rst_done", O_CMD_DONE, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 65, $urandom, $urandom, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
